// File: rtl/conv_mac_pool.sv
// Convolution MAC stage: four 2x2-window lanes accumulate one kernel, then shift, clamp and optional max-pool.
// Build option CONV_ROUND_EN: round-half-up before the post-op shift instead of truncating.
module conv_mac_pool #(
    parameter int unsigned KERNEL_TAPS = 9,
    parameter int unsigned ACC_W       = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_first,
    input  logic [7:0]  in_pix0,
    input  logic [7:0]  in_pix1,
    input  logic [7:0]  in_pix2,
    input  logic [7:0]  in_pix3,
    input  logic [7:0]  in_param,
    input  logic [15:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_pooled,
    output logic        err_seq
);

    localparam int unsigned TAP_W  = $clog2(KERNEL_TAPS + 1);
    localparam int unsigned PROD_W = 17;
    // Headroom so the rounding term never reaches the sign bit, even for shift=31.
    localparam int unsigned SUM_W  = ACC_W + 32;

    typedef enum logic [1:0] {IDLE, ACCUM, POST, HOLD} state_t;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc [4];
    logic [TAP_W-1:0]          tap;
    logic [4:0]                shift_q;
    logic                      relu_q;
    logic                      pool_q;

    logic [7:0]                pix [4];
    logic signed [PROD_W-1:0]  prod [4];
    logic [7:0]                lane_c [4];
    logic [7:0]                pool_c;
    logic                      beat;
    logic                      unused_instr;

    assign beat         = in_valid & in_ready;
    assign unused_instr = ^in_instr[15:7];

    // Shift, then clamp to the unsigned or signed 8-bit range.
    function automatic logic [7:0] post_lane(input logic signed [ACC_W-1:0] a,
                                             input logic [4:0] sh, input logic relu);
        logic signed [SUM_W-1:0] s;
        logic [7:0]              res;
        s = SUM_W'(a);
`ifdef CONV_ROUND_EN
        if (sh != 5'd0) s = s + (SUM_W'(1) <<< (sh - 5'd1));
`else
`endif
        s = s >>> sh;
        if (relu) begin
            if (s < SUM_W'(0))        res = 8'h00;
            else if (s > SUM_W'(255)) res = 8'hFF;
            else                      res = s[7:0];
        end else begin
            if (s < SUM_W'(-128))     res = 8'h80;
            else if (s > SUM_W'(127)) res = 8'h7F;
            else                      res = s[7:0];
        end
        return res;
    endfunction

    always_comb begin
        pix[0] = in_pix0;
        pix[1] = in_pix1;
        pix[2] = in_pix2;
        pix[3] = in_pix3;
        for (int i = 0; i < 4; i++) begin
            prod[i]   = PROD_W'($signed({1'b0, pix[i]})) * PROD_W'($signed(in_param));
            lane_c[i] = post_lane(acc[i], shift_q, relu_q);
        end
        pool_c = lane_c[0];
        for (int i = 1; i < 4; i++) begin
            if (relu_q ? (lane_c[i] > pool_c) : ($signed(lane_c[i]) > $signed(pool_c)))
                pool_c = lane_c[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
            out_pooled <= 1'b0;
            err_seq    <= 1'b0;
            tap        <= '0;
            shift_q    <= 5'd0;
            relu_q     <= 1'b0;
            pool_q     <= 1'b0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat && in_first) begin
                        for (int i = 0; i < 4; i++)
                            acc[i] <= ACC_W'($signed(in_param)) <<< in_instr[4:0];
                        tap     <= '0;
                        shift_q <= in_instr[4:0];
                        relu_q  <= in_instr[5];
                        pool_q  <= in_instr[6];
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        if (in_first) begin
                            // Sequencer restarted mid-group: flag it and begin the new group.
                            err_seq <= 1'b1;
                            for (int i = 0; i < 4; i++)
                                acc[i] <= ACC_W'($signed(in_param)) <<< in_instr[4:0];
                            tap     <= '0;
                            shift_q <= in_instr[4:0];
                            relu_q  <= in_instr[5];
                            pool_q  <= in_instr[6];
                        end else begin
                            for (int i = 0; i < 4; i++)
                                acc[i] <= acc[i] + ACC_W'(prod[i]);
                            tap <= tap + TAP_W'(1);
                            if (tap == TAP_W'(KERNEL_TAPS - 1)) begin
                                in_ready <= 1'b0;
                                state    <= POST;
                            end
                        end
                    end
                end
                POST: begin
                    out_data   <= pool_q ? {24'd0, pool_c}
                                         : {lane_c[3], lane_c[2], lane_c[1], lane_c[0]};
                    out_pooled <= pool_q;
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_pool.sv
// Directed bench for conv_mac_pool; expected values are worked out by hand below.
// The weight is shared by all lanes, so lane3's negative sum comes from a single -1 tap on its own pixel.
module tb_conv_mac_pool;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_first;
    logic [7:0]  in_pix0, in_pix1, in_pix2, in_pix3;
    logic [7:0]  in_param;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_pooled;
    logic        err_seq;

    int checks = 0;
    int errors = 0;

    // Group A (bias 3): lanes sum to 48, 93, 453, -6.  Group B (bias 3, shift 4): lane0 acc 93, others 48.
    localparam logic [31:0] RES_A_RELU = 32'h00FF5D30;
    localparam logic [31:0] RES_A_SGN  = 32'hFA7F5D30;
    localparam logic [31:0] RES_A_POOL = 32'h000000FF;
`ifdef CONV_ROUND_EN
    localparam logic [31:0] RES_B      = 32'h03030306;
`else
    localparam logic [31:0] RES_B      = 32'h03030305;
`endif

    conv_mac_pool dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .in_pix0    (in_pix0),
        .in_pix1    (in_pix1),
        .in_pix2    (in_pix2),
        .in_pix3    (in_pix3),
        .in_param   (in_param),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_pooled (out_pooled),
        .err_seq    (err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was taken.
    task automatic beat(input logic first, input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] p2, input logic [7:0] p3,
                        input logic [7:0] prm, input logic [15:0] ins);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_first = first;
        in_pix0  = p0;
        in_pix1  = p1;
        in_pix2  = p2;
        in_pix3  = p3;
        in_param = prm;
        in_instr = ins;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("beat_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic group(input logic [15:0] ins, input bit grp_b);
        beat(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, ins);
        for (int k = 1; k <= 9; k++) begin
            if (grp_b)       beat(1'b0, 8'd1,  8'd0,  8'd0,   8'd0, 8'(k), 16'd0);
            else if (k == 1) beat(1'b0, 8'd10, 8'd20, 8'd100, 8'd0, 8'd1,  16'd0);
            else if (k == 9) beat(1'b0, 8'd0,  8'd0,  8'd0,   8'd9, 8'hFF, 16'd0);
            else             beat(1'b0, 8'd1,  8'd2,  8'd10,  8'd0, 8'(k), 16'd0);
        end
    endtask

    // Entered one cycle after the last tap edge; the result appears one cycle later.
    task automatic expect_result(input string tag, input logic [31:0] d, input logic p);
        chk({tag, "_latency"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"},  32'(out_valid),  32'd1);
        chk({tag, "_data"},   out_data,        d);
        chk({tag, "_pooled"}, 32'(out_pooled), 32'(p));
        chk({tag, "_ready"},  32'(in_ready),   32'd0);
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_retire_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_retire_ready"}, 32'(in_ready),  32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
        chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
        chk({tag, "_out_data"},   out_data,        32'd0);
        chk({tag, "_out_pooled"}, 32'(out_pooled), 32'd0);
        chk({tag, "_err_seq"},    32'(err_seq),    32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_pix0   = 8'd0;
        in_pix1   = 8'd0;
        in_pix2   = 8'd0;
        in_pix3   = 8'd0;
        in_param  = 8'd0;
        in_instr  = 16'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // Tap beat without a bias beat in IDLE is dropped silently
        beat(1'b0, 8'd5, 8'd5, 8'd5, 8'd5, 8'd7, 16'd0);
        chk("idle_drop_err",   32'(err_seq),   32'd0);
        chk("idle_drop_valid", 32'(out_valid), 32'd0);

        // T1 relu, T2 signed clamp, T3 pooled
        group(16'h0020, 1'b0);
        expect_result("t1", RES_A_RELU, 1'b0);
        retire("t1");
        group(16'h0000, 1'b0);
        expect_result("t2", RES_A_SGN, 1'b0);
        retire("t2");
        group(16'h0060, 1'b0);
        expect_result("t3", RES_A_POOL, 1'b1);
        retire("t3");

        // T4 shift 4 with bias pre-shift
        group(16'h0024, 1'b1);
        expect_result("t4", RES_B, 1'b0);
        retire("t4");

        // T5 back-pressure for 20 cycles
        group(16'h0020, 1'b0);
        expect_result("t5", RES_A_RELU, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_data",  out_data,       RES_A_RELU);
            chk("t5_hold_ready", 32'(in_ready),  32'd0);
        end
        // Bias beat offered in the retire cycle must wait for IDLE
        in_valid  = 1'b1;
        in_first  = 1'b1;
        in_param  = 8'd3;
        in_instr  = 16'h0000;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t5_retire_valid", 32'(out_valid), 32'd0);
        chk("t5_retire_ready", 32'(in_ready),  32'd1);
        group(16'h0000, 1'b0);
        expect_result("t5_next", RES_A_SGN, 1'b0);
        chk("t5_no_err", 32'(err_seq), 32'd0);
        retire("t5_next");

        // T6 restart after 4 taps sets err_seq; the new group is unaffected
        beat(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 16'h0000);
        for (int k = 0; k < 4; k++) beat(1'b0, 8'd9, 8'd9, 8'd9, 8'd9, 8'd5, 16'd0);
        chk("t6_err_before", 32'(err_seq), 32'd0);
        group(16'h0020, 1'b0);
        expect_result("t6", RES_A_RELU, 1'b0);
        chk("t6_err_seq", 32'(err_seq), 32'd1);
        retire("t6");
        chk("t6_err_sticky", 32'(err_seq), 32'd1);

        // T6 reset mid-ACCUM discards partials and clears err_seq
        beat(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 16'h0020);
        for (int k = 0; k < 3; k++) beat(1'b0, 8'd50, 8'd50, 8'd50, 8'd50, 8'd100, 16'd0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        group(16'h0020, 1'b0);
        expect_result("post_reset", RES_A_RELU, 1'b0);
        retire("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
